multiplicador_secuencial: RTL and testbench

MULTIPLICADOR_SECUENCIAL -- requirements
Module: multiplicador_secuencial

---
 rtl/multiplicador_secuencial.sv | 138 +++++++++++++
 tb/tb_multiplicador_secuencial.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/multiplicador_secuencial.sv
// Radix-2 shift-add sequential multiplier, one multiplier bit per cycle.
// Define MULT_SIGNED_EN to honour signed_mode (two's-complement operands).
module multiplicador_secuencial #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               signed_mode,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] O
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    o_q, o_d;

  logic [PW-1:0] mcand;
  logic [PW-1:0] addend;
  logic [PW-1:0] step_sum;
  logic          last_step;

  assign last_step = (cnt_q == LAST);

`ifdef MULT_SIGNED_EN
  logic sgn_q, sgn_d;

  assign mcand = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q}
                       : {{WIDTH{1'b0}}, a_q};
`else
  logic unused_signed_mode;

  assign unused_signed_mode = signed_mode;
  assign mcand = {{WIDTH{1'b0}}, a_q};
`endif

  assign addend = b_q[cnt_q] ? (mcand << cnt_q) : '0;

  // The multiplier MSB carries weight -2^(W-1) in two's complement.
`ifdef MULT_SIGNED_EN
  assign step_sum = (sgn_q && last_step) ? (acc_q - addend)
                                         : (acc_q + addend);
`else
  assign step_sum = acc_q + addend;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last_step) state_d = DONE;
      DONE: state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    O    = o_q;
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    a_d   = a_q;
    b_d   = b_q;
    o_d   = o_q;
`ifdef MULT_SIGNED_EN
    sgn_d = sgn_q;
`endif
    if (state_q == RUN) begin
      acc_d = step_sum;
      cnt_d = cnt_q + CW'(1);
      if (last_step) o_d = step_sum;
    end else if (start) begin
      acc_d = '0;
      cnt_d = '0;
      a_d   = A;
      b_d   = B;
`ifdef MULT_SIGNED_EN
      sgn_d = signed_mode;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      o_q   <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      a_q   <= a_d;
      b_q   <= b_d;
      o_q   <= o_d;
    end
  end

`ifdef MULT_SIGNED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_q <= 1'b0;
    end else begin
      sgn_q <= sgn_d;
    end
  end
`endif

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Bench for multiplicador_secuencial (WIDTH=8): vector table, scoreboard
// of expected products, plus busy, back-to-back and reset sequences.
module tb_multiplicador_secuencial;

  localparam int W   = 8;
  localparam int LAT = W + 1;
`ifdef MULT_SIGNED_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sm;
    logic [2*W-1:0] p;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a_s = '0;
  logic [W-1:0]   b_s = '0;
  logic           sm_s = 1'b0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] o_s;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int n_push = 0;
  logic [2*W-1:0] sb[$];
  vec_t tv[11];

  multiplicador_secuencial #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .A(a_s),
    .B(b_s),
    .signed_mode(sm_s),
    .busy(busy),
    .done(done),
    .O(o_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act,
                       input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_done: got done=1 expected done=0");
      end else begin
        check("product", o_s, sb.pop_front());
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sm, input logic [2*W-1:0] p,
                       input bit push);
    a_s = a;
    b_s = b;
    sm_s = sm;
    start = 1'b1;
    if (push) begin
      sb.push_back(p);
      n_push++;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int lat0);
    int lat;
    int busy_n;
    lat = lat0;
    busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, lat, LAT);
    check({name, "_busy_cycles"}, busy_n, LAT - lat0);
  endtask

  initial begin
    tv[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tv[1]  = '{8'h00, 8'h00, 1'b0, 16'h0000};
    tv[2]  = '{8'h00, 8'hFF, 1'b0, 16'h0000};
    tv[3]  = '{8'h12, 8'h34, 1'b0, 16'h03A8};
    tv[4]  = '{8'hA5, 8'h3C, 1'b0, 16'h26AC};
    tv[5]  = '{8'h01, 8'hFF, 1'b0, 16'h00FF};
    tv[6]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tv[7]  = '{8'hFF, 8'h01, 1'b1, SEN ? 16'hFFFF : 16'h00FF};
    tv[8]  = '{8'h7F, 8'h80, 1'b1, SEN ? 16'hC080 : 16'h3F80};
    tv[9]  = '{8'hFF, 8'hFF, 1'b1, SEN ? 16'h0001 : 16'hFE01};
    tv[10] = '{8'h80, 8'h01, 1'b1, SEN ? 16'hFF80 : 16'h0080};

    #12;
    check("reset_O", o_s, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      issue(tv[i].a, tv[i].b, tv[i].sm, tv[i].p, 1'b1);
      wait_done($sformatf("vec%0d", i), 1);
      @(posedge clk); #1;
    end

    // start and operand changes while busy must not disturb the operation
    issue(8'h07, 8'h09, 1'b0, 16'h003F, 1'b1);
    a_s = 8'h03;
    b_s = 8'h03;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_s = 8'hAA;
    b_s = 8'h55;
    sm_s = 1'b1;
    @(posedge clk); #1;
    wait_done("busy_ignore", 3);
    repeat (12) @(posedge clk);
    #1;
    check("busy_single_done", done_cnt, n_push);

    // back-to-back: start held during the DONE cycle
    issue(8'h02, 8'h04, 1'b0, 16'h0008, 1'b1);
    wait_done("b2b_first", 1);
    issue(8'h03, 8'h05, 1'b0, 16'h000F, 1'b1);
    wait_done("b2b_second", 1);
    @(posedge clk); #1;
    check("O_hold", o_s, 16'h000F);

    // asynchronous reset in the middle of an operation
    issue(8'h12, 8'h34, 1'b0, 16'h0000, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_O", o_s, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(8'h12, 8'h34, 1'b0, 16'h03A8, 1'b1);
    wait_done("after_reset", 1);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    check("done_count", done_cnt, n_push);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
